neuro_frame_sched: RTL and testbench

NEURO_FRAME_SCHED -- requirements
Module: neuro_frame_sched

---
 rtl/neuro_frame_sched.sv | 161 ++++++++++++++++
 tb/tb_neuro_frame_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/neuro_frame_sched.sv
// Frame scheduler: camera request, scale-RAM to network image copy, network GO/latency, result report.
// Optional NEURO_VOTE_EN: report the 2-of-3 majority of the last three results instead of the raw one.
module neuro_frame_sched #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PLANES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_ready,
    output logic        frame_req,
    output logic        rd_en,
    output logic [13:0] rd_addr,
    output logic [1:0]  plane,
    output logic        img_we,
    output logic [15:0] img_addr,
    output logic        nn_go,
    input  logic        nn_stop,
    input  logic [1:0]  nn_result,
    output logic [1:0]  result,
    output logic        result_valid,
    output logic [31:0] cycles,
    output logic        err
);

    localparam int PIX = IMG_W * IMG_H;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_FRAME, LOAD, RUN, DONE} state_t;

    state_t      state;
    logic [1:0]  rd_plane;
    logic [15:0] rd_base;
    logic [31:0] go_cnt;
    logic [31:0] go_cnt_inc;
    logic [1:0]  report_val;

    assign go_cnt_inc = (go_cnt == 32'hFFFF_FFFF) ? go_cnt : go_cnt + 32'd1;

`ifdef NEURO_VOTE_EN
    // The result being captured is the newest history entry; the two older ones are stored here.
    logic [1:0] hist_a;
    logic [1:0] hist_b;
    logic [1:0] fill;

    always_comb begin
        report_val = result;
        if (fill >= 2'd2) begin
            if (nn_result == hist_a || nn_result == hist_b)
                report_val = nn_result;
            else if (hist_a == hist_b)
                report_val = hist_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_a <= 2'd0;
            hist_b <= 2'd0;
            fill   <= 2'd0;
        end else if (state == RUN && nn_stop) begin
            hist_a <= nn_result;
            hist_b <= hist_a;
            if (fill != 2'd3)
                fill <= fill + 2'd1;
        end
    end
`else
    assign report_val = nn_result;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            frame_req    <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= 14'd0;
            rd_plane     <= 2'd0;
            rd_base      <= 16'd0;
            plane        <= 2'd0;
            img_we       <= 1'b0;
            img_addr     <= 16'd0;
            nn_go        <= 1'b0;
            go_cnt       <= 32'd0;
            result       <= 2'd0;
            result_valid <= 1'b0;
            cycles       <= 32'd0;
            err          <= 1'b0;
        end else begin
            // Write side trails the read side by the RAM's one-cycle read latency.
            img_we   <= rd_en;
            plane    <= rd_en ? rd_plane : 2'd0;
            img_addr <= rd_en ? rd_base + {2'b00, rd_addr} : 16'd0;

            if (nn_go)
                go_cnt <= go_cnt_inc;

            if (nn_stop && state != RUN)
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= REQ;
                        frame_req <= 1'b1;
                    end
                end
                REQ: begin
                    frame_req <= 1'b0;
                    state     <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (frame_ready) begin
                        state    <= LOAD;
                        rd_en    <= 1'b1;
                        rd_addr  <= 14'd0;
                        rd_plane <= 2'd1;
                        rd_base  <= 16'd0;
                        nn_go    <= 1'b1;
                        go_cnt   <= 32'd0;
                    end
                end
                LOAD: begin
                    if (rd_addr == 14'(PIX - 1)) begin
                        rd_addr <= 14'd0;
                        if (rd_plane == 2'(PLANES)) begin
                            rd_en    <= 1'b0;
                            rd_plane <= 2'd0;
                            state    <= RUN;
                        end else begin
                            rd_plane <= rd_plane + 2'd1;
                            rd_base  <= rd_base + 16'(PIX);
                        end
                    end else begin
                        rd_addr <= rd_addr + 14'd1;
                    end
                end
                RUN: begin
                    if (nn_stop) begin
                        nn_go        <= 1'b0;
                        cycles       <= go_cnt_inc;
                        result       <= report_val;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    if (enable) begin
                        state     <= REQ;
                        frame_req <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuro_frame_sched.sv
// Randomised bench for neuro_frame_sched on a reduced image size, checked against an index-arithmetic model.
module tb_neuro_frame_sched;

    localparam int W     = 16;
    localparam int H     = 8;
    localparam int P     = 3;
    localparam int PIX   = W * H;
    localparam int TOTAL = PIX * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_ready;
    logic        frame_req;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [1:0]  plane;
    logic        img_we;
    logic [15:0] img_addr;
    logic        nn_go;
    logic        nn_stop;
    logic [1:0]  nn_result;
    logic [1:0]  result;
    logic        result_valid;
    logic [31:0] cycles;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_result = 2'd0;
    logic        exp_err    = 1'b0;
    logic [1:0] hist[$];

    always #5 clk = ~clk;

    neuro_frame_sched #(.IMG_W(W), .IMG_H(H), .PLANES(P)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_ready(frame_ready),
        .frame_req(frame_req), .rd_en(rd_en), .rd_addr(rd_addr), .plane(plane),
        .img_we(img_we), .img_addr(img_addr), .nn_go(nn_go), .nn_stop(nn_stop),
        .nn_result(nn_result), .result(result), .result_valid(result_valid),
        .cycles(cycles), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string ctx);
        check({ctx, "_frame_req"}, frame_req, 0);
        check({ctx, "_rd_en"}, rd_en, 0);
        check({ctx, "_rd_addr"}, rd_addr, 0);
        check({ctx, "_plane"}, plane, 0);
        check({ctx, "_img_we"}, img_we, 0);
        check({ctx, "_img_addr"}, img_addr, 0);
        check({ctx, "_nn_go"}, nn_go, 0);
        check({ctx, "_result"}, result, 0);
        check({ctx, "_result_valid"}, result_valid, 0);
        check({ctx, "_cycles"}, cycles, 0);
        check({ctx, "_err"}, err, 0);
    endtask

    // Expected reported class after one more network result.
    function automatic logic [1:0] model_report(input logic [1:0] res);
`ifdef NEURO_VOTE_EN
        hist.push_front(res);
        if (hist.size() > 3) void'(hist.pop_back());
        if (hist.size() == 3) begin
            if (hist[0] == hist[1] || hist[0] == hist[2]) return hist[0];
            if (hist[1] == hist[2]) return hist[1];
        end
        return exp_result;
`else
        return res;
`endif
    endfunction

    // Entered with the DUT in WAIT_FRAME; leaves it in WAIT_FRAME with enable=1.
    task automatic run_frame(input int wait_cyc, input int dly, input logic [1:0] res,
                             input bit drop_en, input bit early_ready_drop, input bit inject_err);
        int we_seen;
        frame_ready = 1'b0;
        if (inject_err) begin
            nn_stop = 1'b1;
            nn_result = 2'd3;
            tick();
            nn_stop = 1'b0;
            exp_err = 1'b1;
            check("err_set_in_wait", err, 1);
            check("wait_hold_rd_en", rd_en, 0);
            check("wait_hold_nn_go", nn_go, 0);
            check("wait_hold_frame_req", frame_req, 0);
        end
        repeat (wait_cyc) tick();
        check("wait_no_read", rd_en, 0);
        frame_ready = 1'b1;
        tick();
        we_seen = 0;
        for (int i = 0; i < dly; i++) begin
            check("nn_go_high", nn_go, 1);
            if (i < TOTAL) begin
                check("rd_en_load", rd_en, 1);
                check("rd_addr", rd_addr, i % PIX);
            end else begin
                check("rd_en_run", rd_en, 0);
            end
            if (i >= 1 && i <= TOTAL) begin
                check("img_addr", img_addr, i - 1);
                check("plane", plane, (i - 1) / PIX + 1);
            end else begin
                check("img_we_idle", img_we, 0);
                check("plane_idle", plane, 0);
            end
            we_seen += int'(img_we);
            if (i == 2 && early_ready_drop) frame_ready = 1'b0;
            if (i == 10 && drop_en) enable = 1'b0;
            if (i == dly - 1) begin
                nn_stop = 1'b1;
                nn_result = res;
            end
            tick();
        end
        nn_stop = 1'b0;
        frame_ready = 1'b0;
        exp_result = model_report(res);
        check("img_we_count", we_seen, TOTAL);
        check("nn_go_drop", nn_go, 0);
        check("result_valid_pulse", result_valid, 1);
        check("cycles", cycles, dly);
        check("result", result, exp_result);
        check("err_sticky", err, exp_err);
        tick();
        check("result_valid_end", result_valid, 0);
        if (enable) begin
            check("req_again", frame_req, 1);
            tick();
            check("req_one_cycle", frame_req, 0);
        end else begin
            check("idle_no_req", frame_req, 0);
            repeat (3 + $urandom_range(0, 5)) tick();
            check("idle_stays", frame_req, 0);
            enable = 1'b1;
            tick();
            check("req_from_idle", frame_req, 1);
            tick();
            check("req_from_idle_end", frame_req, 0);
        end
        $display("frame res=%0d dly=%0d cycles=%0d result=%0d exp=%0d", res, dly, cycles, result, exp_result);
    endtask

    logic [1:0] res_tab [6] = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3};

    initial begin
        int dly;
        logic [1:0] res;
        rst_n = 1'b0;
        enable = 1'b0;
        frame_ready = 1'b0;
        nn_stop = 1'b0;
        nn_result = 2'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_without_enable", frame_req, 0);
        enable = 1'b1;
        tick();
        check("first_req", frame_req, 1);
        tick();
        check("first_req_end", frame_req, 0);

        for (int f = 0; f < 8; f++) begin
            res = (f < 6) ? res_tab[f] : 2'($urandom_range(0, 3));
            dly = (f == 1) ? 1000 : TOTAL + 2 + int'($urandom_range(0, 40));
            run_frame(int'($urandom_range(0, 6)), dly, res, f == 2 || f == 6,
                      f == 3 || f == 7, f == 0);
        end

        // Abort in the middle of plane 2 with an asynchronous reset.
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        for (int i = 0; i < PIX + 5; i++) tick();
        check("abort_rd_addr", rd_addr, 5);
        check("abort_plane", plane, 2);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check_all_zero("abort");
        tick();
        rst_n = 1'b1;
        exp_err = 1'b0;
        exp_result = 2'd0;
        hist.delete();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("no_valid_after_abort", result_valid, 0);
        end
        check("err_cleared", err, 0);
        enable = 1'b1;
        tick();
        check("req_after_abort", frame_req, 1);
        tick();
        run_frame(2, TOTAL + 5, 2'd2, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
